// File: rtl/chan_select_reg_pkg.sv
// rtl/chan_select_reg_pkg.sv - shared types for the registered N:1 channel selector
package chan_select_reg_pkg;

  // LIVE: follows ticks; PEND: switch waiting for a tick; FROZEN: display held
  typedef enum logic [1:0] {
    LIVE   = 2'd0,
    PEND   = 2'd1,
    FROZEN = 2'd2
  } csel_state_t;

  // Select width for a channel count; never below one bit
  function automatic int sel_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/chan_select_reg_if.sv
// rtl/chan_select_reg_if.sv - channel/select/display bundle between counters and selector
interface chan_select_reg_if
  import chan_select_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
);
  localparam int SELW = sel_width(NCH);

  logic [NCH*WIDTH-1:0] ch_data;
  logic [SELW-1:0]      sel;
  logic                 sel_req;
  logic                 tick;
  logic                 hold;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 pending;
  logic                 sel_err;

  // Driver side: counters and control feeding the selector
  modport master (
    output ch_data, sel, sel_req, tick, hold,
    input  out_data, out_sel, out_valid, pending, sel_err
  );

  // Selector side
  modport slave (
    input  ch_data, sel, sel_req, tick, hold,
    output out_data, out_sel, out_valid, pending, sel_err
  );

endinterface

// File: rtl/chan_select_reg_mux_n.sv
// rtl/chan_select_reg_mux_n.sv - combinational N:1 word multiplexer
module mux_n
  import chan_select_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = sel_width(NCH)
) (
  input  logic [NCH*WIDTH-1:0] data_i,
  input  logic [SELW-1:0]      sel_i,
  output logic [WIDTH-1:0]     data_o
);

  // Compare against each channel index so an out-of-range select yields zero
  always_comb begin
    data_o = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_i == SELW'(k)) data_o = data_i[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/chan_select_reg.sv
// rtl/chan_select_reg.sv - registered N:1 channel selector with tick-deferred switching and hold
module chan_select_reg
  import chan_select_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  chan_select_reg_if.slave   bus
);

  localparam int          SELW  = sel_width(NCH);
  localparam logic [31:0] NCH_U = NCH;

  csel_state_t      state_q, state_d;
  logic             pend_q, pend_d;
  logic [SELW-1:0]  pend_sel_q, pend_sel_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;

  logic             sel_oob;
  logic             req_ok;
  logic [SELW-1:0]  mux_sel;
  logic [WIDTH-1:0] mux_data;

  assign sel_oob = ({{(32-SELW){1'b0}}, bus.sel} >= NCH_U);
  assign req_ok  = bus.sel_req & ~sel_oob;

  // In PEND the next tick shows the pending channel, otherwise the current one
  assign mux_sel = (state_q == PEND) ? pend_sel_q : out_sel_q;

  mux_n #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) u_mux (
    .data_i (bus.ch_data),
    .sel_i  (mux_sel),
    .data_o (mux_data)
  );

  // Next-state and output-register update rules
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_sel_d  = pend_sel_q;
    out_sel_d   = out_sel_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sel_err_d   = bus.sel_req & sel_oob;

    // A valid request is always captured; only the state transition varies
    if (req_ok) pend_sel_d = bus.sel;

    case (state_q)
      LIVE: begin
        if (bus.hold) begin
          state_d = FROZEN;
          pend_d  = req_ok;
        end else begin
          if (bus.tick) begin
            out_data_d  = mux_data;
            out_valid_d = 1'b1;
          end
          if (req_ok) state_d = PEND;
        end
      end
      PEND: begin
        if (bus.hold) begin
          state_d = FROZEN;
          pend_d  = 1'b1;
        end else if (bus.tick) begin
          out_sel_d   = pend_sel_q;
          out_data_d  = mux_data;
          out_valid_d = 1'b1;
          state_d     = req_ok ? PEND : LIVE;
        end
      end
      FROZEN: begin
        if (!bus.hold) begin
          state_d = (pend_q | req_ok) ? PEND : LIVE;
          pend_d  = 1'b0;
        end else if (req_ok) begin
          pend_d = 1'b1;
        end
      end
      default: begin
        state_d = LIVE;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any pending switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LIVE;
      pend_q      <= 1'b0;
      pend_sel_q  <= '0;
      out_sel_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_sel_q  <= pend_sel_d;
      out_sel_q   <= out_sel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.pending   = (state_q == PEND) | ((state_q == FROZEN) & pend_q);

endmodule

// File: tb/tb_chan_select_reg.sv
// tb/tb_chan_select_reg.sv - self-checking bench for chan_select_reg against a rule-level model
module tb_chan_select_reg;

  localparam int WIDTH = 16;
  localparam int NCH   = 5;
  localparam int SELW  = $clog2(NCH);

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  chan_select_reg_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  chan_select_reg #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the display shows and what is waiting
  bit              m_frozen;
  bit              m_waiting;
  int              m_want;
  int              m_shown_ch;
  logic [WIDTH-1:0] m_shown;
  bit              m_valid;
  bit              m_err;

  function automatic logic [WIDTH-1:0] chan(input int k);
    return bus.ch_data[k*WIDTH +: WIDTH];
  endfunction

  task automatic set_chan(input int k, input logic [WIDTH-1:0] v);
    bus.ch_data[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic model_reset();
    m_frozen = 0; m_waiting = 0; m_want = 0;
    m_shown_ch = 0; m_shown = '0; m_valid = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit good;
    m_err = bus.sel_req && (int'(bus.sel) >= NCH);
    good  = bus.sel_req && !m_err;
    if (m_frozen) begin
      if (!bus.hold) m_frozen = 0;
    end else if (bus.hold) begin
      m_frozen = 1;
    end else if (bus.tick) begin
      if (m_waiting) begin
        m_shown_ch = m_want;
        m_waiting  = 0;
      end
      m_shown = chan(m_shown_ch);
      m_valid = 1;
    end
    if (good) begin
      m_want    = int'(bus.sel);
      m_waiting = 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    bus.sel_req = 1'b0;
    bus.tick    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ch_data = '0; bus.sel = '0; bus.sel_req = 1'b0; bus.tick = 1'b0; bus.hold = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_data !== '0 || bus.out_valid !== 1'b0 || bus.out_sel !== '0 ||
        bus.pending !== 1'b0 || bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: data=%h valid=%b sel=%0d pend=%b err=%b, required all zero",
               bus.out_data, bus.out_valid, bus.out_sel, bus.pending, bus.sel_err);
    end
  endtask

  task automatic test_first_tick();
    set_chan(0, 16'h1234);
    bus.tick = 1'b1;
    cyc();
    checks++;
    if (bus.out_data !== 16'h1234 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_tick: data=%h valid=%b, required 1234 1", bus.out_data, bus.out_valid);
    end
  endtask

  task automatic test_switch();
    set_chan(2, 16'hBEEF);
    bus.sel = SELW'(2); bus.sel_req = 1'b1;
    cyc();
    repeat (5) cyc();
    checks++;
    if (bus.out_data !== 16'h1234 || bus.pending !== 1'b1) begin
      errors++;
      $display("FAIL switch_wait: data=%h pend=%b, required 1234 1", bus.out_data, bus.pending);
    end
    bus.tick = 1'b1;
    cyc();
    checks++;
    if (bus.out_data !== 16'hBEEF || bus.out_sel !== SELW'(2) || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL switch_apply: data=%h sel=%0d pend=%b, required beef 2 0",
               bus.out_data, bus.out_sel, bus.pending);
    end
  endtask

  task automatic test_hold();
    bus.hold = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      set_chan(0, 16'(16'h0100 + i));
      set_chan(2, 16'(16'h0200 + i));
      bus.tick = 1'b1;
      cyc();
      checks++;
      if (bus.out_data !== 16'hBEEF) begin
        errors++;
        $display("FAIL hold_frozen[%0d]: data=%h, required beef", i, bus.out_data);
      end
    end
    set_chan(1, 16'hCAFE);
    bus.sel = SELW'(1); bus.sel_req = 1'b1;
    cyc();
    checks++;
    if (bus.pending !== 1'b1 || bus.out_sel !== SELW'(2)) begin
      errors++;
      $display("FAIL hold_req: pend=%b sel=%0d, required 1 2", bus.pending, bus.out_sel);
    end
    bus.hold = 1'b0;
    cyc();
    bus.tick = 1'b1;
    cyc();
    checks++;
    if (bus.out_sel !== SELW'(1) || bus.out_data !== 16'hCAFE) begin
      errors++;
      $display("FAIL hold_release: sel=%0d data=%h, required 1 cafe", bus.out_sel, bus.out_data);
    end
  endtask

  task automatic test_sel_err();
    bus.sel = SELW'(5); bus.sel_req = 1'b1;
    cyc();
    checks++;
    if (bus.sel_err !== 1'b1 || bus.out_sel !== SELW'(1) || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL sel_err_pulse: err=%b sel=%0d pend=%b, required 1 1 0",
               bus.sel_err, bus.out_sel, bus.pending);
    end
    cyc();
    checks++;
    if (bus.sel_err !== 1'b0 || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL sel_err_clear: err=%b pend=%b, required 0 0", bus.sel_err, bus.pending);
    end
  endtask

  task automatic test_same_cycle();
    set_chan(1, 16'hAAAA); set_chan(3, 16'hBBBB); set_chan(0, 16'hC0C0);
    bus.tick = 1'b1; bus.sel = SELW'(3); bus.sel_req = 1'b1;
    cyc();
    checks++;
    if (bus.out_data !== 16'hAAAA || bus.out_sel !== SELW'(1) || bus.pending !== 1'b1) begin
      errors++;
      $display("FAIL live_tick_req: data=%h sel=%0d pend=%b, required aaaa 1 1",
               bus.out_data, bus.out_sel, bus.pending);
    end
    bus.tick = 1'b1; bus.sel = SELW'(0); bus.sel_req = 1'b1;
    cyc();
    checks++;
    if (bus.out_data !== 16'hBBBB || bus.out_sel !== SELW'(3) || bus.pending !== 1'b1) begin
      errors++;
      $display("FAIL pend_tick_req: data=%h sel=%0d pend=%b, required bbbb 3 1",
               bus.out_data, bus.out_sel, bus.pending);
    end
    bus.tick = 1'b1;
    cyc();
    checks++;
    if (bus.out_data !== 16'hC0C0 || bus.out_sel !== SELW'(0) || bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL pend_second: data=%h sel=%0d pend=%b, required c0c0 0 0",
               bus.out_data, bus.out_sel, bus.pending);
    end
    bus.sel = SELW'(1); bus.sel_req = 1'b1; cyc();
    bus.sel = SELW'(3); bus.sel_req = 1'b1; cyc();
    bus.tick = 1'b1; cyc();
    checks++;
    if (bus.out_sel !== SELW'(3) || bus.out_data !== 16'hBBBB) begin
      errors++;
      $display("FAIL last_wins: sel=%0d data=%h, required 3 bbbb", bus.out_sel, bus.out_data);
    end
  endtask

  task automatic test_async_reset();
    bus.sel = SELW'(2); bus.sel_req = 1'b1;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.out_data !== '0 || bus.out_sel !== '0 || bus.out_valid !== 1'b0 ||
        bus.pending !== 1'b0 || bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: data=%h sel=%0d valid=%b pend=%b err=%b, required all zero",
               bus.out_data, bus.out_sel, bus.out_valid, bus.pending, bus.sel_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_chan(0, 16'h5A5A);
    bus.tick = 1'b1;
    cyc();
    checks++;
    if (bus.out_data !== 16'h5A5A || bus.out_sel !== '0 || bus.out_valid !== 1'b1 ||
        bus.pending !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_tick: data=%h sel=%0d valid=%b pend=%b, required 5a5a 0 1 0",
               bus.out_data, bus.out_sel, bus.out_valid, bus.pending);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NCH; k++) set_chan(k, 16'($urandom));
      bus.tick    = ($urandom_range(0, 3) == 0);
      bus.sel_req = ($urandom_range(0, 3) == 0);
      bus.sel     = SELW'($urandom_range(0, (1 << SELW) - 1));
      if ($urandom_range(0, 15) == 0) bus.hold = ~bus.hold;
      cyc();
      checks++;
      if (bus.out_data !== m_shown || bus.out_sel !== SELW'(m_shown_ch) ||
          bus.out_valid !== m_valid || bus.pending !== m_waiting || bus.sel_err !== m_err) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: data=%h sel=%0d valid=%b pend=%b err=%b, required %h %0d %b %b %b",
                   i, bus.out_data, bus.out_sel, bus.out_valid, bus.pending, bus.sel_err,
                   m_shown, m_shown_ch, m_valid, m_waiting, m_err);
      end
    end
    bus.hold = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_first_tick();
    test_switch();
    test_hold();
    test_sel_err();
    test_same_cycle();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
